corejtagdebug_tunnel_ctrl: RTL and testbench

Target-side endpoint of the CoreJTAGDebug tunnelled-scan protocol. It sits behind the UJTAG user interface, clocked by TCK. When the UJTAG IR matches `IR_CODE`, it decodes each DR-scan packet serially. It replays the encoded TMS traversals and payload onto a target TAP through a clock-enable interface, and returns target TDO on UTDO.

---
 rtl/corejtagdebug_pkg.sv | 28 ++
 rtl/corejtagdebug_tun_field_cnt.sv | 36 +++
 rtl/corejtagdebug_tunnel_ctrl.sv | 166 ++++++++++++++++
 tb/tb_corejtagdebug_tunnel_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corejtagdebug_pkg.sv
// Shared types and constants for the CoreJTAGDebug tunnel endpoint.
// State enum, field widths, header overhead and a length helper.
package corejtagdebug_pkg;

  localparam int TRAV_LEN_W   = 3;
  localparam int PL_LEN_W     = 6;
  localparam int TUN_HDR_BITS = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IN_LEN,
    S_IN_TMS,
    S_PL_LEN,
    S_PL,
    S_OUT_LEN,
    S_OUT_TMS,
    S_DONE
  } tun_state_t;

  // A 3-bit field shifted LSB first lands in the top bits.
  function automatic logic [PL_LEN_W-1:0] trav_len(
    input logic [PL_LEN_W-1:0] v
  );
    return {{(PL_LEN_W-TRAV_LEN_W){1'b0}},
            v[PL_LEN_W-1 -: TRAV_LEN_W]};
  endfunction

endpackage

// File: rtl/corejtagdebug_tun_field_cnt.sv
// Length shift register plus remaining-bit down-counter.
// Ports: clk, rst_n, load/load_val, dec/bit_in -> last, val_nxt.
module corejtagdebug_tun_field_cnt
  import corejtagdebug_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [PL_LEN_W-1:0] load_val,
  input  logic                dec,
  input  logic                bit_in,
  output logic                last,
  output logic [PL_LEN_W-1:0] val_nxt
);

  logic [PL_LEN_W-1:0] cnt;
  logic [PL_LEN_W-1:0] sh;

  // Value including the bit being shifted this cycle.
  assign val_nxt = {bit_in, sh[PL_LEN_W-1:1]};
  assign last    = (cnt == PL_LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sh  <= '0;
    end else if (load) begin
      cnt <= load_val;
      sh  <= '0;
    end else if (dec) begin
      cnt <= cnt - PL_LEN_W'(1);
      sh  <= val_nxt;
    end
  end

endmodule

// File: rtl/corejtagdebug_tunnel_ctrl.sv
// Tunnelled-scan decoder: replays packet TMS/TDI onto a target TAP.
// Ports: UJTAG user side (UIREG, UDR*, UTDI/UTDO), TGT_* side, pulses.
module corejtagdebug_tunnel_ctrl
  import corejtagdebug_pkg::*;
#(
  parameter logic [7:0] IR_CODE = 8'h55
) (
  input  logic       TCK,
  input  logic       TRSTB,
  input  logic [7:0] UIREG,
  input  logic       UDRCAP,
  input  logic       UDRSH,
  input  logic       UDRUPD,
  input  logic       UTDI,
  output logic       UTDO,
  output logic       TGT_TCK_EN,
  output logic       TGT_TMS,
  output logic       TGT_TDI,
  input  logic       TGT_TDO,
  output logic       PKT_DONE,
  output logic       PKT_ERR
);

  tun_state_t state_q, state_d;

  logic sel, shift;
  logic fc_load, fc_dec, last;
  logic [PL_LEN_W-1:0] fc_val, val_nxt, tlen;
  logic tck_en_d, tms_d, tdi_d;
  logic done_d, err_d, pl_clk_d;
  logic tck_en_q, tms_q, tdi_q;
  logic done_q, err_q, pl_clk_q;
  logic tdo_q, ret_q;

  assign sel   = (UIREG == IR_CODE);
  assign shift = sel && UDRSH;
  assign tlen  = trav_len(val_nxt);

  corejtagdebug_tun_field_cnt u_fcnt (
    .clk      (TCK),
    .rst_n    (TRSTB),
    .load     (fc_load),
    .load_val (fc_val),
    .dec      (fc_dec),
    .bit_in   (UTDI),
    .last     (last),
    .val_nxt  (val_nxt)
  );

  always_comb begin
    state_d  = state_q;
    fc_load  = 1'b0;
    fc_val   = '0;
    fc_dec   = 1'b0;
    tck_en_d = 1'b0;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pl_clk_d = 1'b0;
    if (sel && UDRUPD) begin
      state_d = S_IDLE;
      done_d  = (state_q == S_DONE);
      err_d   = (state_q != S_DONE) &&
                (state_q != S_IDLE);
    end else if (sel && UDRCAP) begin
      state_d = S_IN_LEN;
      fc_load = 1'b1;
      fc_val  = PL_LEN_W'(TRAV_LEN_W);
    end else if (shift) begin
      fc_dec = (state_q != S_IDLE) &&
               (state_q != S_DONE);
      unique case (state_q)
        S_IN_LEN: if (last) begin
          fc_load = 1'b1;
          if (tlen == '0) begin
            state_d = S_PL_LEN;
            fc_val  = PL_LEN_W'(PL_LEN_W);
          end else begin
            state_d = S_IN_TMS;
            fc_val  = tlen;
          end
        end
        S_IN_TMS: begin
          tck_en_d = 1'b1;
          tms_d    = UTDI;
          if (last) begin
            state_d = S_PL_LEN;
            fc_load = 1'b1;
            fc_val  = PL_LEN_W'(PL_LEN_W);
          end
        end
        S_PL_LEN: if (last) begin
          fc_load = 1'b1;
          if (val_nxt == '0) begin
            state_d = S_OUT_LEN;
            fc_val  = PL_LEN_W'(TRAV_LEN_W);
          end else begin
            state_d = S_PL;
            fc_val  = val_nxt;
          end
        end
        S_PL: begin
          tck_en_d = 1'b1;
          tdi_d    = UTDI;
          // Last payload bit steps the target to Exit1.
          tms_d    = last;
          pl_clk_d = 1'b1;
          if (last) begin
            state_d = S_OUT_LEN;
            fc_load = 1'b1;
            fc_val  = PL_LEN_W'(TRAV_LEN_W);
          end
        end
        S_OUT_LEN: if (last) begin
          if (tlen == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_OUT_TMS;
            fc_load = 1'b1;
            fc_val  = tlen;
          end
        end
        S_OUT_TMS: begin
          tck_en_d = 1'b1;
          tms_d    = UTDI;
          if (last) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge TCK or negedge TRSTB) begin
    if (!TRSTB) begin
      state_q  <= S_IDLE;
      tck_en_q <= 1'b0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      pl_clk_q <= 1'b0;
      tdo_q    <= 1'b0;
      ret_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tck_en_q <= tck_en_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      done_q   <= done_d;
      err_q    <= err_d;
      pl_clk_q <= pl_clk_d;
      // Capture target TDO on the edge the target shifts.
      if (pl_clk_q) tdo_q <= TGT_TDO;
      ret_q    <= pl_clk_q;
    end
  end

  assign TGT_TCK_EN = tck_en_q;
  assign TGT_TMS    = tms_q;
  assign TGT_TDI    = tdi_q;
  assign PKT_DONE   = done_q;
  assign PKT_ERR    = err_q;
  assign UTDO       = sel && ret_q && tdo_q;

endmodule

// File: tb/tb_corejtagdebug_tunnel_ctrl.sv
// Bench for corejtagdebug_tunnel_ctrl with a behavioural target TAP.
// Directed protocol scenarios followed by randomized packets.
module tb_corejtagdebug_tunnel_ctrl;
  import corejtagdebug_pkg::*;

  localparam logic [31:0] IDCODE = 32'h1E02A1CF;

  logic TCK = 1'b0;
  logic TRSTB;
  logic [7:0] UIREG;
  logic UDRCAP, UDRSH, UDRUPD, UTDI;
  logic UTDO, TGT_TCK_EN, TGT_TMS, TGT_TDI;
  logic TGT_TDO, PKT_DONE, PKT_ERR;

  int n_chk = 0;
  int n_err = 0;

  always #5 TCK = ~TCK;

  corejtagdebug_tunnel_ctrl #(.IR_CODE(8'h55)) dut (
    .TCK        (TCK),
    .TRSTB      (TRSTB),
    .UIREG      (UIREG),
    .UDRCAP     (UDRCAP),
    .UDRSH      (UDRSH),
    .UDRUPD     (UDRUPD),
    .UTDI       (UTDI),
    .UTDO       (UTDO),
    .TGT_TCK_EN (TGT_TCK_EN),
    .TGT_TMS    (TGT_TMS),
    .TGT_TDI    (TGT_TDI),
    .TGT_TDO    (TGT_TDO),
    .PKT_DONE   (PKT_DONE),
    .PKT_ERR    (PKT_ERR)
  );

  // Target TAP: 0 TLR,1 RTI,2 SelDR,3 CapDR,4 ShDR,5 Ex1DR,
  // 6 PauDR,7 Ex2DR,8 UpdDR,9 SelIR,10 CapIR,11 ShIR,
  // 12 Ex1IR,13 PauIR,14 Ex2IR,15 UpdIR
  int tap_st = 0;
  logic [4:0] ir = 5'h1F;
  logic [4:0] ir_sh = 5'h0;
  logic [31:0] dr_sh = 32'h0;

  function automatic int tap_nxt(input int s, input logic t);
    case (s)
      0:  return t ? 0  : 1;
      1:  return t ? 2  : 1;
      2:  return t ? 9  : 3;
      3:  return t ? 5  : 4;
      4:  return t ? 5  : 4;
      5:  return t ? 8  : 6;
      6:  return t ? 7  : 6;
      7:  return t ? 8  : 4;
      8:  return t ? 2  : 1;
      9:  return t ? 0  : 10;
      10: return t ? 12 : 11;
      11: return t ? 12 : 11;
      12: return t ? 15 : 13;
      13: return t ? 14 : 13;
      14: return t ? 15 : 11;
      default: return t ? 2 : 1;
    endcase
  endfunction

  assign TGT_TDO = (tap_st == 4)  ? dr_sh[0] :
                   (tap_st == 11) ? ir_sh[0] : 1'b0;

  logic rec_tms[$];
  logic rec_tdi[$];
  logic rec_tdo[$];

  always @(posedge TCK) begin
    if (TGT_TCK_EN) begin
      rec_tms.push_back(TGT_TMS);
      rec_tdi.push_back(TGT_TDI);
      rec_tdo.push_back(TGT_TDO);
      case (tap_st)
        3:  dr_sh <= IDCODE;
        4:  dr_sh <= {TGT_TDI, dr_sh[31:1]};
        10: ir_sh <= 5'b00001;
        11: ir_sh <= {TGT_TDI, ir_sh[4:1]};
        15: ir    <= ir_sh;
        default: ;
      endcase
      tap_st <= tap_nxt(tap_st, TGT_TMS);
    end
  end

  // Reference packet: serial bits plus the target clocks it implies.
  logic pkt[$];
  logic exp_tms[$];
  logic exp_tdi[$];
  logic exp_pl[$];
  int   exp_pos[$];
  int   pl0, plen, ilen, n_pkt;
  logic [31:0] ret_word;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic add_clk(input logic t, input logic d,
                         input logic p);
    exp_pos.push_back(pkt.size());
    exp_tms.push_back(t);
    exp_tdi.push_back(d);
    exp_pl.push_back(p);
  endtask

  task automatic build(input int il, input logic [6:0] it,
                       input int pl, input logic [63:0] pay,
                       input int ol, input logic [6:0] ot);
    pkt.delete();
    exp_tms.delete();
    exp_tdi.delete();
    exp_pl.delete();
    exp_pos.delete();
    for (int i = 0; i < 3; i++) pkt.push_back(il[i]);
    for (int i = 0; i < il; i++) begin
      add_clk(it[i], 1'b0, 1'b0);
      pkt.push_back(it[i]);
    end
    for (int i = 0; i < 6; i++) pkt.push_back(pl[i]);
    pl0  = pkt.size();
    plen = pl;
    ilen = il;
    for (int i = 0; i < pl; i++) begin
      add_clk(i == pl - 1, pay[i], 1'b1);
      pkt.push_back(pay[i]);
    end
    for (int i = 0; i < 3; i++) pkt.push_back(ol[i]);
    for (int i = 0; i < ol; i++) begin
      add_clk(ot[i], 1'b0, 1'b0);
      pkt.push_back(ot[i]);
    end
    n_pkt = TUN_HDR_BITS + il + pl + ol;
  endtask

  // Capture, shift m bits, two idle cycles, update.
  task automatic run_pkt(input logic [7:0] irv, input int m);
    logic s;
    int n_exp, n_cmp;
    s = (irv == 8'h55);
    rec_tms.delete();
    rec_tdi.delete();
    rec_tdo.delete();
    ret_word = '0;
    UIREG  = irv;
    UDRCAP = 1'b1;
    @(negedge TCK);
    UDRCAP = 1'b0;
    for (int c = 0; c <= m + 1; c++) begin
      int k;
      logic e;
      k = c - 2 - pl0;
      e = 1'b0;
      if (s && k >= 0 && k < plen && pl0 + k < m) begin
        if (ilen + k < rec_tdo.size()) e = rec_tdo[ilen + k];
        if (k < 32) ret_word[k] = UTDO;
      end
      chk("utdo", {31'b0, UTDO}, {31'b0, e});
      if (c < m) begin
        UDRSH = 1'b1;
        UTDI  = pkt[c];
      end else begin
        UDRSH = 1'b0;
        UTDI  = 1'($urandom);
      end
      @(negedge TCK);
    end
    UDRUPD = 1'b1;
    @(negedge TCK);
    UDRUPD = 1'b0;
    chk("pkt_done", {31'b0, PKT_DONE},
        {31'b0, s && m == n_pkt});
    chk("pkt_err", {31'b0, PKT_ERR},
        {31'b0, s && m < n_pkt});
    @(negedge TCK);
    chk("pulse_end", {30'b0, PKT_DONE, PKT_ERR}, 32'd0);
    n_exp = 0;
    if (s)
      foreach (exp_pos[i]) if (exp_pos[i] < m) n_exp++;
    chk("n_tclk", rec_tms.size(), n_exp);
    n_cmp = (rec_tms.size() < n_exp) ? rec_tms.size() : n_exp;
    for (int i = 0; i < n_cmp; i++) begin
      chk("tgt_tms", {31'b0, rec_tms[i]}, {31'b0, exp_tms[i]});
      if (exp_pl[i])
        chk("tgt_tdi", {31'b0, rec_tdi[i]},
            {31'b0, exp_tdi[i]});
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk(tag, {26'b0, TGT_TMS, TGT_TDI, TGT_TCK_EN,
              UTDO, PKT_DONE, PKT_ERR},
        32'b100000);
  endtask

  initial begin
    logic [7:0] r;
    int il, pl, ol, m;
    TRSTB  = 1'b0;
    UIREG  = 8'h55;
    UDRCAP = 1'b0;
    UDRSH  = 1'b0;
    UDRUPD = 1'b0;
    UTDI   = 1'b0;
    #12;
    check_reset_outs("reset_vals");
    @(negedge TCK);
    TRSTB = 1'b1;
    @(negedge TCK);

    // Tunnelled reset: one TMS=0 clock, TLR -> RTI.
    build(1, 7'b0, 0, 64'b0, 0, 7'b0);
    run_pkt(8'h55, n_pkt);
    chk("tap_rti", tap_st, 1);

    // Tunnelled IR scan.
    build(4, 7'b0011, 5, 64'b00001, 2, 7'b01);
    run_pkt(8'h55, n_pkt);
    chk("ir_nclk", rec_tms.size(), 11);
    chk("tgt_ir", {27'b0, ir}, 32'd1);
    chk("ir_rti", tap_st, 1);

    // Tunnelled DR scan returning IDCODE.
    build(3, 7'b001, 32, 64'b0, 2, 7'b01);
    run_pkt(8'h55, n_pkt);
    chk("dr_nclk", rec_tms.size(), 37);
    chk("idcode", ret_word, IDCODE);
    chk("dr_rti", tap_st, 1);

    // IR mismatch: nothing reaches the target.
    run_pkt(8'hAA, n_pkt);

    // Abort after 20 of 49 bits, then recover.
    run_pkt(8'h55, 20);
    build(6, 7'b011111, 0, 64'b0, 0, 7'b0);
    run_pkt(8'h55, n_pkt);
    chk("abort_rti", tap_st, 1);
    build(3, 7'b001, 32, 64'b0, 2, 7'b01);
    run_pkt(8'h55, n_pkt);
    chk("abort_idcode", ret_word, IDCODE);

    // Reset asserted while payload is streaming.
    UIREG  = 8'h55;
    UDRCAP = 1'b1;
    @(negedge TCK);
    UDRCAP = 1'b0;
    for (int c = 0; c < pl0 + 5; c++) begin
      UDRSH = 1'b1;
      UTDI  = pkt[c];
      @(negedge TCK);
    end
    chk("pl_tck_en", {31'b0, TGT_TCK_EN}, 32'd1);
    #2;
    TRSTB = 1'b0;
    #1;
    check_reset_outs("rst_async");
    UDRSH = 1'b0;
    @(negedge TCK);
    TRSTB = 1'b1;
    UDRUPD = 1'b1;
    @(negedge TCK);
    UDRUPD = 1'b0;
    chk("rst_no_pulse", {30'b0, PKT_DONE, PKT_ERR}, 32'd0);
    build(6, 7'b011111, 0, 64'b0, 0, 7'b0);
    run_pkt(8'h55, n_pkt);
    build(3, 7'b001, 32, 64'b0, 2, 7'b01);
    run_pkt(8'h55, n_pkt);
    chk("rst_idcode", ret_word, IDCODE);

    // Randomized packets, some unselected or truncated.
    for (int it = 0; it < 30; it++) begin
      il = $urandom_range(0, 7);
      pl = $urandom_range(0, 63);
      ol = $urandom_range(0, 7);
      build(il, 7'($urandom), pl, {$urandom, $urandom},
            ol, 7'($urandom));
      r = 8'h55;
      if ($urandom_range(0, 4) == 0) begin
        r = 8'($urandom);
        if (r == 8'h55) r = 8'h56;
      end
      m = n_pkt;
      if ($urandom_range(0, 3) == 0)
        m = $urandom_range(0, n_pkt - 1);
      run_pkt(r, m);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
